// File: rtl/atm_pkg.sv
// Shared encodings for the multi-account ATM controller: operations, FSM states
// and response error codes.
package atm_pkg;

    typedef enum logic [2:0] {
        OP_BAL = 3'd3,
        OP_WD  = 3'd4,
        OP_DEP = 3'd5,
        OP_PIN = 3'd6
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd7,
        ST_CHK_ACC = 3'd1,
        ST_CHK_PIN = 3'd2,
        ST_EXEC    = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ERR_OK       = 3'd0,
        ERR_BAD_ACC  = 3'd1,
        ERR_BAD_PIN  = 3'd2,
        ERR_LOCKED   = 3'd3,
        ERR_INSUFF   = 3'd4,
        ERR_LIMIT    = 3'd5,
        ERR_OVERFLOW = 3'd6,
        ERR_BAD_OP   = 3'd7
    } err_e;

endpackage

// File: rtl/atm_account_db.sv
// Per-account register file (PIN, balance, try counter, lock, daily withdrawal
// total) with one combinational read port, one whole-entry write port and a global total clear.
module atm_account_db #(
    parameter int ACC_W = 4,
    parameter int PIN_W = 16,
    parameter int BAL_W = 32,
    parameter int TRY_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_wd,
    input  logic [ACC_W-1:0] rd_idx,
    output logic [PIN_W-1:0] rd_pin,
    output logic [BAL_W-1:0] rd_bal,
    output logic [TRY_W-1:0] rd_tries,
    output logic             rd_lock,
    output logic [BAL_W-1:0] rd_wd,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_idx,
    input  logic [PIN_W-1:0] wr_pin,
    input  logic [BAL_W-1:0] wr_bal,
    input  logic [TRY_W-1:0] wr_tries,
    input  logic             wr_lock,
    input  logic [BAL_W-1:0] wr_wd
);

    localparam int DEPTH = 2 ** ACC_W;

    logic [PIN_W-1:0] pin_q   [DEPTH];
    logic [PIN_W-1:0] pin_d   [DEPTH];
    logic [BAL_W-1:0] bal_q   [DEPTH];
    logic [BAL_W-1:0] bal_d   [DEPTH];
    logic [TRY_W-1:0] tries_q [DEPTH];
    logic [TRY_W-1:0] tries_d [DEPTH];
    logic             lock_q  [DEPTH];
    logic             lock_d  [DEPTH];
    logic [BAL_W-1:0] wd_q    [DEPTH];
    logic [BAL_W-1:0] wd_d    [DEPTH];

    assign rd_pin   = pin_q[rd_idx];
    assign rd_bal   = bal_q[rd_idx];
    assign rd_tries = tries_q[rd_idx];
    assign rd_lock  = lock_q[rd_idx];
    assign rd_wd    = wd_q[rd_idx];

    // The write port lands after the rollover clear so a same-cycle write wins.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pin_d[i]   = pin_q[i];
            bal_d[i]   = bal_q[i];
            tries_d[i] = tries_q[i];
            lock_d[i]  = lock_q[i];
            wd_d[i]    = clr_wd ? '0 : wd_q[i];
        end
        if (wr_en) begin
            pin_d[wr_idx]   = wr_pin;
            bal_d[wr_idx]   = wr_bal;
            tries_d[wr_idx] = wr_tries;
            lock_d[wr_idx]  = wr_lock;
            wd_d[wr_idx]    = wr_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pin_q[i]   <= '0;
                bal_q[i]   <= '0;
                tries_q[i] <= '0;
                lock_q[i]  <= 1'b0;
                wd_q[i]    <= '0;
            end
        end else begin
            pin_q   <= pin_d;
            bal_q   <= bal_d;
            tries_q <= tries_d;
            lock_q  <= lock_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: rtl/atm_multi_account_ctrl.sv
// Multi-account ATM transaction controller: valid/ready request intake, account and
// PIN checks, withdraw/deposit/PIN-change execution and a one-cycle response strobe.
module atm_multi_account_ctrl
    import atm_pkg::*;
#(
    parameter int NUM_ACC   = 10,
    parameter int ACC_W     = 4,
    parameter int PIN_W     = 16,
    parameter int BAL_W     = 32,
    parameter int MAX_TRIES = 3,
    parameter int WD_LIMIT  = 20000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       operation,
    input  logic [ACC_W-1:0] acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] new_pin,
    input  logic [BAL_W-1:0] amount,
    input  logic             language,
    input  logic             day_rollover,
    input  logic             cfg_we,
    input  logic [ACC_W-1:0] cfg_acc,
    input  logic [PIN_W-1:0] cfg_pin,
    input  logic [BAL_W-1:0] cfg_bal,
    output logic             resp_valid,
    output logic             success,
    output logic [2:0]       err_code,
    output logic [BAL_W-1:0] balance,
    output logic             lang_out,
    output logic [2:0]       state
);

    localparam int               TRY_W      = $clog2(MAX_TRIES + 1);
    localparam logic [BAL_W:0]   WD_LIMIT_W = (BAL_W + 1)'(WD_LIMIT);
    localparam logic [ACC_W-1:0] MAX_ACC    = ACC_W'(NUM_ACC);

    function automatic logic acc_valid(input logic [ACC_W-1:0] a);
        return (a != '0) && (a <= MAX_ACC);
    endfunction

    state_e           state_q, state_d;
    logic             resp_valid_q, resp_valid_d;
    logic             success_q, success_d;
    logic [2:0]       err_q, err_d;
    logic [BAL_W-1:0] bal_out_q, bal_out_d;
    logic             lang_out_q, lang_out_d;

    logic [2:0]       op_q, op_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [PIN_W-1:0] pin_q, pin_d;
    logic [PIN_W-1:0] new_pin_q, new_pin_d;
    logic [BAL_W-1:0] amount_q, amount_d;
    logic             lang_q, lang_d;
    err_e             err_res_q, err_res_d;
    logic [BAL_W-1:0] bal_res_q, bal_res_d;

    logic [PIN_W-1:0] rd_pin;
    logic [BAL_W-1:0] rd_bal;
    logic [TRY_W-1:0] rd_tries;
    logic             rd_lock;
    logic [BAL_W-1:0] rd_wd;
    logic             wr_en;
    logic [ACC_W-1:0] wr_idx;
    logic [PIN_W-1:0] wr_pin;
    logic [BAL_W-1:0] wr_bal;
    logic [TRY_W-1:0] wr_tries;
    logic             wr_lock;
    logic [BAL_W-1:0] wr_wd;

    logic [BAL_W-1:0] wd_base;
    logic [BAL_W:0]   wd_sum;
    logic [BAL_W:0]   dep_sum;
    logic [TRY_W-1:0] tries_inc;

    atm_account_db #(
        .ACC_W (ACC_W),
        .PIN_W (PIN_W),
        .BAL_W (BAL_W),
        .TRY_W (TRY_W)
    ) u_db (
        .clk      (clk),
        .rst      (rst),
        .clr_wd   (day_rollover),
        .rd_idx   (acc_q),
        .rd_pin   (rd_pin),
        .rd_bal   (rd_bal),
        .rd_tries (rd_tries),
        .rd_lock  (rd_lock),
        .rd_wd    (rd_wd),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_pin   (wr_pin),
        .wr_bal   (wr_bal),
        .wr_tries (wr_tries),
        .wr_lock  (wr_lock),
        .wr_wd    (wr_wd)
    );

    assign req_ready  = (state_q == ST_IDLE) && !cfg_we;
    assign resp_valid = resp_valid_q;
    assign success    = success_q;
    assign err_code   = err_q;
    assign balance    = bal_out_q;
    assign lang_out   = lang_out_q;
    assign state      = state_q;

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        success_d    = success_q;
        err_d        = err_q;
        bal_out_d    = bal_out_q;
        lang_out_d   = lang_out_q;
        op_d         = op_q;
        acc_d        = acc_q;
        pin_d        = pin_q;
        new_pin_d    = new_pin_q;
        amount_d     = amount_q;
        lang_d       = lang_q;
        err_res_d    = err_res_q;
        bal_res_d    = bal_res_q;

        // A rollover in this cycle means the stored total is already stale.
        wd_base   = day_rollover ? '0 : rd_wd;
        wd_sum    = {1'b0, wd_base} + {1'b0, amount_q};
        dep_sum   = {1'b0, rd_bal} + {1'b0, amount_q};
        tries_inc = rd_tries + TRY_W'(1);

        wr_en    = 1'b0;
        wr_idx   = acc_q;
        wr_pin   = rd_pin;
        wr_bal   = rd_bal;
        wr_tries = rd_tries;
        wr_lock  = rd_lock;
        wr_wd    = wd_base;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    if (acc_valid(cfg_acc)) begin
                        wr_en    = 1'b1;
                        wr_idx   = cfg_acc;
                        wr_pin   = cfg_pin;
                        wr_bal   = cfg_bal;
                        wr_tries = '0;
                        wr_lock  = 1'b0;
                        wr_wd    = '0;
                    end
                end else if (req_valid) begin
                    op_d      = operation;
                    acc_d     = acc_num;
                    pin_d     = pin;
                    new_pin_d = new_pin;
                    amount_d  = amount;
                    lang_d    = language;
                    err_res_d = ERR_OK;
                    bal_res_d = '0;
                    state_d   = ST_CHK_ACC;
                end
            end
            ST_CHK_ACC: begin
                state_d = ST_RESP;
                if (!acc_valid(acc_q)) begin
                    err_res_d = ERR_BAD_ACC;
                end else if (rd_lock) begin
                    err_res_d = ERR_LOCKED;
                end else if ((op_q < 3'd3) || (op_q > 3'd6)) begin
                    err_res_d = ERR_BAD_OP;
                end else begin
                    state_d = ST_CHK_PIN;
                end
            end
            ST_CHK_PIN: begin
                wr_en = 1'b1;
                if (pin_q != rd_pin) begin
                    wr_tries  = tries_inc;
                    wr_lock   = (tries_inc >= TRY_W'(MAX_TRIES));
                    err_res_d = ERR_BAD_PIN;
                    state_d   = ST_RESP;
                end else begin
                    wr_tries = '0;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d   = ST_RESP;
                err_res_d = ERR_OK;
                bal_res_d = rd_bal;
                case (op_q)
                    OP_WD: begin
                        if (amount_q > rd_bal) begin
                            err_res_d = ERR_INSUFF;
                        end else if (wd_sum > WD_LIMIT_W) begin
                            err_res_d = ERR_LIMIT;
                        end else begin
                            wr_en     = 1'b1;
                            wr_bal    = rd_bal - amount_q;
                            wr_wd     = wd_sum[BAL_W] ? '1 : wd_sum[BAL_W-1:0];
                            bal_res_d = rd_bal - amount_q;
                        end
                    end
                    OP_DEP: begin
                        if (dep_sum[BAL_W]) begin
                            err_res_d = ERR_OVERFLOW;
                        end else begin
                            wr_en     = 1'b1;
                            wr_bal    = dep_sum[BAL_W-1:0];
                            bal_res_d = dep_sum[BAL_W-1:0];
                        end
                    end
                    OP_PIN: begin
                        if (new_pin_q == rd_pin) begin
                            err_res_d = ERR_BAD_OP;
                        end else begin
                            wr_en  = 1'b1;
                            wr_pin = new_pin_q;
                        end
                    end
                    default: ;
                endcase
            end
            ST_RESP: begin
                resp_valid_d = 1'b1;
                success_d    = (err_res_q == ERR_OK);
                err_d        = err_res_q;
                bal_out_d    = (err_res_q == ERR_OK) ? bal_res_q : '0;
                lang_out_d   = lang_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            success_q    <= 1'b0;
            err_q        <= '0;
            bal_out_q    <= '0;
            lang_out_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            success_q    <= success_d;
            err_q        <= err_d;
            bal_out_q    <= bal_out_d;
            lang_out_q   <= lang_out_d;
        end
    end

    // Request holding registers; only meaningful once a request is accepted.
    always_ff @(posedge clk) begin
        op_q      <= op_d;
        acc_q     <= acc_d;
        pin_q     <= pin_d;
        new_pin_q <= new_pin_d;
        amount_q  <= amount_d;
        lang_q    <= lang_d;
        err_res_q <= err_res_d;
        bal_res_q <= bal_res_d;
    end

endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Scoreboard bench for atm_multi_account_ctrl: requests push expected responses,
// a negedge monitor pops and compares them, including response latency.
module tb_atm_multi_account_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [31:0] amount;
    logic        language;
    logic        day_rollover;
    logic        cfg_we;
    logic [3:0]  cfg_acc;
    logic [15:0] cfg_pin;
    logic [31:0] cfg_bal;
    logic        resp_valid;
    logic        success;
    logic [2:0]  err_code;
    logic [31:0] balance;
    logic        lang_out;
    logic [2:0]  state;

    typedef struct {
        logic [2:0]  err;
        logic [31:0] bal;
        logic        lang;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    atm_multi_account_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .operation    (operation),
        .acc_num      (acc_num),
        .pin          (pin),
        .new_pin      (new_pin),
        .amount       (amount),
        .language     (language),
        .day_rollover (day_rollover),
        .cfg_we       (cfg_we),
        .cfg_acc      (cfg_acc),
        .cfg_pin      (cfg_pin),
        .cfg_bal      (cfg_bal),
        .resp_valid   (resp_valid),
        .success      (success),
        .err_code     (err_code),
        .balance      (balance),
        .lang_out     (lang_out),
        .state        (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                exp_t x;
                x = sb_q.pop_front();
                check_eq("err_code", 64'(err_code), 64'(x.err));
                check_eq("success", 64'(success), 64'(x.err == 3'd0));
                check_eq("balance", 64'(balance), 64'(x.bal));
                check_eq("lang_out", 64'(lang_out), 64'(x.lang));
                check_eq("latency", 64'(cyc - x.acc_cyc), 64'(x.lat));
            end
        end
    end

    task automatic cfg(input logic [3:0] a, input logic [15:0] p, input logic [31:0] b);
        @(negedge clk);
        cfg_we = 1'b1; cfg_acc = a; cfg_pin = p; cfg_bal = b;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_rollover();
        @(negedge clk);
        day_rollover = 1'b1;
        @(negedge clk);
        day_rollover = 1'b0;
    endtask

    task automatic do_req(input logic [2:0] op, input logic [3:0] a, input logic [15:0] p,
                          input logic [15:0] np, input logic [31:0] amt, input logic lang,
                          input logic [2:0] e, input logic [31:0] b, input int lat,
                          input bit roll_exec);
        exp_t x;
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        operation = op; acc_num = a; pin = p; new_pin = np; amount = amt; language = lang;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        x.err = e; x.bal = b; x.lang = lang; x.lat = lat; x.acc_cyc = cyc;
        sb_q.push_back(x);
        if (roll_exec) begin
            repeat (2) @(negedge clk);
            day_rollover = 1'b1;
            @(negedge clk);
            day_rollover = 1'b0;
        end
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check_eq("resp_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; operation = '0; acc_num = '0; pin = '0; new_pin = '0;
        amount = '0; language = 1'b0; day_rollover = 1'b0; cfg_we = 1'b0; cfg_acc = '0;
        cfg_pin = '0; cfg_bal = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_state", 64'(state), 64'd7);
        check_eq("rst_ready", 64'(req_ready), 64'd1);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("rst_balance", 64'(balance), 64'd0);
        rst = 1'b0;

        // Balance inquiry on a programmed account.
        cfg(4'd1, 16'd1234, 32'd5000);
        do_req(3'd3, 4'd1, 16'd1234, 16'd0, 32'd0, 1'b1, 3'd0, 32'd5000, 4, 1'b0);

        // Reset while the request sits in EXEC: no response, everything cleared.
        @(negedge clk);
        operation = 3'd3; acc_num = 4'd1; pin = 16'd1234; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("st_chk_acc", 64'(state), 64'd1);
        @(negedge clk);
        check_eq("st_chk_pin", 64'(state), 64'd2);
        @(negedge clk);
        check_eq("st_exec", 64'(state), 64'd3);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_state", 64'(state), 64'd7);
        check_eq("midrst_ready", 64'(req_ready), 64'd1);
        check_eq("midrst_resp_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        do_req(3'd3, 4'd1, 16'd0, 16'd0, 32'd0, 1'b0, 3'd0, 32'd0, 4, 1'b0);

        // Wrong-PIN lockout.
        cfg(4'd1, 16'd1234, 32'd5000);
        for (int i = 0; i < 3; i++)
            do_req(3'd3, 4'd1, 16'd1111, 16'd0, 32'd0, 1'b0, 3'd2, 32'd0, 3, 1'b0);
        do_req(3'd3, 4'd1, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd3, 32'd0, 2, 1'b0);

        // Daily withdrawal limit and rollover.
        cfg(4'd2, 16'd2222, 32'd30000);
        do_req(3'd4, 4'd2, 16'd2222, 16'd0, 32'd15000, 1'b0, 3'd0, 32'd15000, 4, 1'b0);
        do_req(3'd4, 4'd2, 16'd2222, 16'd0, 32'd6000, 1'b0, 3'd5, 32'd0, 4, 1'b0);
        pulse_rollover();
        do_req(3'd4, 4'd2, 16'd2222, 16'd0, 32'd6000, 1'b1, 3'd0, 32'd9000, 4, 1'b0);

        // Rollover coinciding with a withdraw in EXEC counts it against a fresh total.
        cfg(4'd4, 16'd4444, 32'd50000);
        do_req(3'd4, 4'd4, 16'd4444, 16'd0, 32'd20000, 1'b0, 3'd0, 32'd30000, 4, 1'b0);
        do_req(3'd4, 4'd4, 16'd4444, 16'd0, 32'd1, 1'b0, 3'd5, 32'd0, 4, 1'b0);
        do_req(3'd4, 4'd4, 16'd4444, 16'd0, 32'd5000, 1'b0, 3'd0, 32'd25000, 4, 1'b1);
        do_req(3'd4, 4'd4, 16'd4444, 16'd0, 32'd15000, 1'b0, 3'd0, 32'd10000, 4, 1'b0);
        do_req(3'd4, 4'd4, 16'd4444, 16'd0, 32'd1, 1'b0, 3'd5, 32'd0, 4, 1'b0);

        // Deposit overflow and insufficient funds near the top of the range.
        cfg(4'd3, 16'd3333, 32'hFFFF_FF00);
        do_req(3'd5, 4'd3, 16'd3333, 16'd0, 32'h200, 1'b0, 3'd6, 32'd0, 4, 1'b0);
        do_req(3'd3, 4'd3, 16'd3333, 16'd0, 32'd0, 1'b0, 3'd0, 32'hFFFF_FF00, 4, 1'b0);
        do_req(3'd4, 4'd3, 16'd3333, 16'd0, 32'hFFFF_FF01, 1'b0, 3'd4, 32'd0, 4, 1'b0);
        do_req(3'd4, 4'd3, 16'd3333, 16'd0, 32'd0, 1'b0, 3'd0, 32'hFFFF_FF00, 4, 1'b0);

        // Bad account, bad operation and PIN change.
        do_req(3'd3, 4'd0, 16'd0, 16'd0, 32'd0, 1'b0, 3'd1, 32'd0, 2, 1'b0);
        do_req(3'd3, 4'd11, 16'd0, 16'd0, 32'd0, 1'b0, 3'd1, 32'd0, 2, 1'b0);
        do_req(3'd2, 4'd2, 16'd2222, 16'd0, 32'd0, 1'b0, 3'd7, 32'd0, 2, 1'b0);
        cfg(4'd5, 16'd1234, 32'd100);
        do_req(3'd6, 4'd5, 16'd1234, 16'd1234, 32'd0, 1'b0, 3'd7, 32'd0, 4, 1'b0);
        do_req(3'd6, 4'd5, 16'd1234, 16'd5678, 32'd0, 1'b0, 3'd0, 32'd100, 4, 1'b0);
        do_req(3'd3, 4'd5, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd2, 32'd0, 3, 1'b0);
        do_req(3'd5, 4'd5, 16'd5678, 16'd0, 32'd50, 1'b1, 3'd0, 32'd150, 4, 1'b0);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/atm_multi_account_ctrl.md
Name: atm_multi_account_ctrl

Overview:
- Parametrised successor ATM transaction controller with NUM_ACC accounts, configurable widths, and a valid/ready request handshake.
- Adds features the current ATM block lacks: per-account wrong-PIN lockout, a daily withdrawal limit with a rollover pulse, deposit overflow protection, explicit error codes, and a runtime account-programming port.
- Sits between the card/keypad front end and the display/bookkeeping logic.

Parameters:
- NUM_ACC, 10, number of accounts; valid acc_num is 1..NUM_ACC.
- ACC_W, 4, account number width; must satisfy 2**ACC_W > NUM_ACC.
- PIN_W, 16, PIN width.
- BAL_W, 32, balance and amount width.
- MAX_TRIES, 3, consecutive wrong PINs before an account is locked.
- WD_LIMIT, 20000, maximum cumulative withdrawal per account per day.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- operation  in  3  3 = balance, 4 = withdraw, 5 = deposit, 6 = change PIN; any other value is invalid.
- acc_num  in  ACC_W  account number.
- pin  in  PIN_W  entered PIN.
- new_pin  in  PIN_W  replacement PIN for operation 6.
- amount  in  BAL_W  withdraw or deposit amount.
- language  in  1  display language; latched and echoed only.
- day_rollover  in  1  single-cycle pulse that clears all withdrawal totals.
- cfg_we  in  1  account programming write enable.
- cfg_acc  in  ACC_W  account to program.
- cfg_pin  in  PIN_W  PIN to program.
- cfg_bal  in  BAL_W  balance to program.
- resp_valid  out  1  one-cycle response strobe.
- success  out  1  transaction succeeded; valid while resp_valid is high.
- err_code  out  3  0 OK, 1 BAD_ACC, 2 BAD_PIN, 3 LOCKED, 4 INSUFF, 5 LIMIT, 6 OVERFLOW, 7 BAD_OP_OR_SAME_PIN.
- balance  out  BAL_W  account balance after the transaction; 0 on any failure.
- lang_out  out  1  language latched with the request.
- state  out  3  current FSM state.

Behaviour:
- Reset (asynchronous, rst = 1):
  - FSM enters IDLE.
  - All outputs are 0 except req_ready = 1 and state = 3'd7.
  - All PINs, balances, try counters, lock bits and withdrawal totals clear to 0.
  - A request in flight is dropped; no response is issued.
- FSM states and encodings: IDLE = 7, CHK_ACC = 1, CHK_PIN = 2, EXEC = 3, RESP = 4.
- IDLE:
  - req_ready = ~cfg_we.
  - A request is accepted when req_valid & req_ready. All inputs are latched on that edge and the FSM goes to CHK_ACC.
  - cfg_we writes the account's PIN and balance and clears its try counter, lock bit and withdrawal total. cfg_we is honoured only in IDLE and is ignored elsewhere.
  - cfg_acc outside 1..NUM_ACC is ignored.
- CHK_ACC:
  - acc_num of 0 or greater than NUM_ACC -> BAD_ACC -> RESP.
  - Account locked -> LOCKED -> RESP.
  - Operation not in 3..6 -> code 7 -> RESP.
  - Otherwise -> CHK_PIN.
- CHK_PIN:
  - PIN mismatch: try counter increments, error BAD_PIN. The lock bit sets when the counter reaches MAX_TRIES. Go to RESP.
  - PIN match: try counter clears, go to EXEC.
- EXEC:
  - Balance (3): no state change.
  - Withdraw (4):
    - amount > balance -> INSUFF.
    - else withdrawal total + amount > WD_LIMIT -> LIMIT.
    - else balance -= amount and withdrawal total += amount.
    - An amount of 0 succeeds and changes nothing.
  - Deposit (5): sum computed at BAL_W+1 bits; carry out -> OVERFLOW and balance unchanged; else balance += amount.
  - Change PIN (6): new_pin == stored PIN -> code 7; else the stored PIN is updated.
  - Go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, with success = (err_code == 0).
  - balance = post-operation value on success, 0 on failure.
  - Next state is IDLE.
- Latency: a successful request's response arrives 4 clocks after the accepting edge. A failure detected in CHK_ACC arrives after 2 clocks; one detected in CHK_PIN arrives after 3 clocks.
- day_rollover:
  - Honoured in any state.
  - If it coincides with a withdraw in EXEC, totals clear first and that withdraw is then counted against the fresh total.
- Outputs (success, err_code, balance, lang_out) hold their values until the next RESP. Only resp_valid pulses.
- All arithmetic is unsigned. The withdrawal total saturates and never wraps.

Decomposition:
- atm_pkg holds:
  - op_e (OP_BAL = 3, OP_WD = 4, OP_DEP = 5, OP_PIN = 6);
  - state_e with the encodings above;
  - err_e with the codes above.
- Sub-module atm_account_db:
  - register arrays indexed by account, with one read port and one write port;
  - holds PIN, balance, try counter, lock bit and withdrawal total;
  - uses the same asynchronous reset.
- The FSM and arithmetic live in the top module.

Test Plan:
- Reset: with rst = 1, state == 7, req_ready = 1, resp_valid = 0. The same holds after a rst pulse mid-EXEC, with no response issued.
- Program acc 1 with PIN 1234 and balance 5000, then request balance -> resp_valid 4 clocks after accept, success = 1, balance = 5000.
- Acc 1 wrong PIN 3 times -> BAD_PIN, BAD_PIN, LOCKED transition on the third try. The fourth attempt, even with PIN 1234, returns LOCKED after 2 clocks.
- Acc 2 with balance 30000: withdraw 15000 (OK), then withdraw 6000 -> LIMIT. Pulse day_rollover, retry withdraw 6000 -> OK, balance = 9000.
- Acc 3 with balance 0xFFFF_FF00: deposit 0x200 -> OVERFLOW, balance unchanged. Withdraw 0xFFFF_FF01 -> INSUFF.
- acc_num 0 or 11 -> BAD_ACC. Operation 2 -> code 7. Change PIN 1234 -> 1234 -> code 7. Change PIN 1234 -> 5678 succeeds, and an old-PIN request then returns BAD_PIN.
